pulse_stretcher: RTL and testbench

- Output-side counterpart of the input debouncer: converts single-cycle one-shot pulses into clean, human-visible levels (e.g. LED, external handshake line).
- Each accepted pulse yields a level held high for HOLD_CYCLES, followed by a guaranteed low gap of GAP_CYCLES so that back-to-back events stay distinguishable.
- Pulses arriving while busy are counted and replayed in order.

---
 rtl/pulse_stretcher_pkg.sv | 18 +
 rtl/pulse_stretcher_timer.sv | 27 ++
 rtl/pulse_stretcher.sv | 120 ++++++++++++
 tb/tb_pulse_stretcher.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher.
// One-shot pulses become held levels with a forced low gap between them.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } pulse_stretcher_state_e;

  localparam logic TRUE_STRETCHER  = 1'b1;
  localparam logic FALSE_STRETCHER = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_stretcher_timer.sv
// Loadable down-counter shared by the HOLD and GAP phases.
// Stops at zero; done flags an expired count.
module stretch_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches one-shot pulses into HOLD-high / GAP-low levels.
// Pulses seen while busy are queued and replayed in order.
import pulse_stretcher_pkg::*;

module pulse_stretcher #(
  parameter int HOLD_CYCLES = 1_500_000,
  parameter int GAP_CYCLES  = 500_000,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  input  logic              clear_overflow,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int TW =
    $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  pulse_stretcher_state_e state_q, state_d;

  logic              tmr_load;
  logic [TW-1:0]     tmr_value;
  logic              tmr_done;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              ovf_evt;
  logic              enqueue;

  stretch_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .load_value (tmr_value),
    .done       (tmr_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_load  = FALSE_STRETCHER;
    tmr_value = HOLD_LD;
    pend_d    = pend_q;
    enqueue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pulse_in) begin
          state_d   = HOLD;
          tmr_load  = TRUE_STRETCHER;
          tmr_value = HOLD_LD;
        end
      end
      HOLD: begin
        enqueue = pulse_in;
        if (tmr_done) begin
          state_d   = GAP;
          tmr_load  = TRUE_STRETCHER;
          tmr_value = GAP_LD;
        end
      end
      GAP: begin
        if (!tmr_done) begin
          enqueue = pulse_in;
        end else if (pend_q != '0 || pulse_in) begin
          // A pulse on the last GAP cycle is consumed directly
          state_d   = HOLD;
          tmr_load  = TRUE_STRETCHER;
          tmr_value = HOLD_LD;
          if (!pulse_in) begin
            pend_d = pend_q - PEND_W'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ovf_evt = enqueue && (pend_q == PEND_MAX);
    if (enqueue && !ovf_evt) begin
      pend_d = pend_q + PEND_W'(1);
    end
  end

  // A new drop outranks a clear in the same cycle
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_evt) begin
      ovf_d = 1'b1;
    end else if (clear_overflow) begin
      ovf_d = 1'b0;
    end
  end

  assign level_out = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign pending   = pend_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher (HOLD=4, GAP=2, PEND_W=2).
// Stimulus pushes per-cycle expectations; a negedge monitor checks them.
module tb_pulse_stretcher;

  logic       clk;
  logic       rst;
  logic       pulse_in;
  logic       clear_overflow;
  logic       level_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int checks;
  int failures;

  typedef struct {
    string      nm;
    int         cyc;
    logic       lvl;
    logic       bsy;
    logic [1:0] pnd;
    logic       ovf;
  } exp_t;

  exp_t q[$];

  pulse_stretcher #(
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (2),
    .PEND_W      (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pulse_in       (pulse_in),
    .clear_overflow (clear_overflow),
    .level_out      (level_out),
    .busy           (busy),
    .pending        (pending),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks += 4;
      if (level_out !== e.lvl) begin
        failures++;
        $display("FAIL %s cyc%0d level_out got=%0b exp=%0b",
                 e.nm, e.cyc, level_out, e.lvl);
      end
      if (busy !== e.bsy) begin
        failures++;
        $display("FAIL %s cyc%0d busy got=%0b exp=%0b",
                 e.nm, e.cyc, busy, e.bsy);
      end
      if (pending !== e.pnd) begin
        failures++;
        $display("FAIL %s cyc%0d pending got=%0d exp=%0d",
                 e.nm, e.cyc, pending, e.pnd);
      end
      if (overflow !== e.ovf) begin
        failures++;
        $display("FAIL %s cyc%0d overflow got=%0b exp=%0b",
                 e.nm, e.cyc, overflow, e.ovf);
      end
    end
  end

  task automatic push_exp(input string nm, input int cyc,
                          input logic l, input logic b,
                          input logic [1:0] p, input logic o);
    exp_t e;
    e.nm  = nm;
    e.cyc = cyc;
    e.lvl = l;
    e.bsy = b;
    e.pnd = p;
    e.ovf = o;
    q.push_back(e);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 8 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s drain timeout left=%0d exp=0", nm, q.size());
      q.delete();
    end
  endtask

  task automatic apply_reset();
    rst            = 1'b0;
    pulse_in       = 1'b0;
    clear_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  task automatic run_test(input string nm,
                          input string p, input string c,
                          input string l, input string b,
                          input string pd, input string o);
    for (int k = 0; k < p.len(); k++) begin
      @(posedge clk);
      #1;
      pulse_in       = (p[k] == "1");
      clear_overflow = (c[k] == "1");
      push_exp(nm, k, l[k] == "1", b[k] == "1",
               2'(pd[k] - "0"), o[k] == "1");
    end
    drain(nm);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b0;
    pulse_in       = 1'b0;
    clear_overflow = 1'b0;

    @(posedge clk);
    #1;
    push_exp("reset_state", 0, 1'b0, 1'b0, 2'd0, 1'b0);
    drain("reset_state");

    apply_reset();
    run_test("single",
             "100000000",
             "000000000",
             "011110000",
             "011111100",
             "000000000",
             "000000000");

    apply_reset();
    run_test("queued",
             "101000000000000",
             "000000000000000",
             "011110011110000",
             "011111111111100",
             "000111100000000",
             "000000000000000");

    apply_reset();
    run_test("last_gap",
             "100000100000000",
             "000000000000000",
             "011110011110000",
             "011111111111100",
             "000000000000000",
             "000000000000000");

    apply_reset();
    run_test("overflow",
             "111111000000000000000000000",
             "000000001000000000000000000",
             "011110011110011110011110000",
             "011111111111111111111111100",
             "001233322222211111100000000",
             "000001111000000000000000000");

    apply_reset();
    run_test("ovf_collide",
             "1111110000",
             "0000010100",
             "0111100111",
             "0111111111",
             "0012333222",
             "0000011100");

    apply_reset();
    run_test("reset_mid",
             "11",
             "00",
             "01",
             "01",
             "00",
             "00");
    @(posedge clk);
    #1;
    pulse_in = 1'b0;
    #1;
    rst = 1'b0;
    push_exp("reset_mid", 2, 1'b0, 1'b0, 2'd0, 1'b0);
    drain("reset_mid");
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    run_test("after_reset",
             "100000000",
             "000000000",
             "011110000",
             "011111100",
             "000000000",
             "000000000");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
